// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/gnt port,
// buffers in-order responses in a small FIFO and hands them to decode via valid/ready.
// A redirect flushes the FIFO and drops every response still in flight.
module riscv_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  localparam int unsigned     AW  = $clog2(DEPTH);
  localparam int unsigned     CW  = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]   aq_wptr_q, aq_wptr_d, aq_rptr_q, aq_rptr_d;
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] aq_q         [DEPTH];

  logic          pop, grant, drop, push;
  logic [CW:0]   credit_used;

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != '0);
  assign if_instr  = fifo_instr_q[rptr_q];
  assign if_pc     = fifo_pc_q[rptr_q];

  // Handshake decode; the request credit counts the slot freed by this cycle's pop.
  always_comb begin
    pop         = if_valid & id_ready & ~redirect_valid;
    credit_used = {1'b0, count_q} + {1'b0, outstanding_q} - {{CW{1'b0}}, pop};
    imem_req    = ~RST & ~redirect_valid & (credit_used < (CW + 1)'(DEPTH));
    grant       = imem_req & imem_gnt;
    drop        = imem_rvalid & (discard_q != '0);
    push        = imem_rvalid & ~drop & ~redirect_valid;
  end

  // Next-state for PC, counters and pointers; redirect overrides the FIFO state.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    aq_wptr_d     = aq_wptr_q;
    aq_rptr_d     = aq_rptr_q;

    if (grant) begin
      pc_d      = pc_q + XLEN'(4);
      aq_wptr_d = aq_wptr_q + AW'(1);
    end
    if (imem_rvalid) aq_rptr_d = aq_rptr_q + AW'(1);

    case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: ;
    endcase

    if (drop) discard_d = discard_q - CW'(1);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      // A response landing in the redirect cycle is already excluded here.
      discard_d = outstanding_q - CW'(imem_rvalid);
    end
  end

  // State registers and FIFO/address-queue storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      aq_wptr_q     <= '0;
      aq_rptr_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= NOP;
        fifo_pc_q[i]    <= RESET_PC;
        aq_q[i]         <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      aq_wptr_q     <= aq_wptr_d;
      aq_rptr_q     <= aq_rptr_d;
      if (push) begin
        fifo_instr_q[wptr_q] <= imem_rdata;
        fifo_pc_q[wptr_q]    <= aq_q[aq_rptr_q];
      end
      if (grant) aq_q[aq_wptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: in-order variable-latency memory model plus a
// stream-level reference (expected PC sequence, in-flight/buffered bookkeeping by epoch).
module tb_riscv_fetch;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, id_ready;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;

  riscv_fetch #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  always #5 CLK = ~CLK;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory / reference model state
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_epoch[$];
  int          mq_due[$];
  int          epoch = 0;
  int          buffered = 0;
  int          drops = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  // Deliveries as observed on the DUT outputs
  int          dp_cyc[$];
  logic [31:0] dp_pc[$];
  logic [31:0] dp_instr[$];
  // Snapshot of the last evaluated cycle
  int          s_cyc;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  task automatic clear_deliveries();
    dp_cyc.delete();
    dp_pc.delete();
    dp_instr.delete();
  endtask

  // One clock: sample and score at the negedge, advance, then drive memory outputs.
  task automatic cycle();
    bit pop_m;
    bit exp_req;
    logic [31:0] a;
    int ep;
    @(negedge CLK);
    s_cyc = cyc;
    s_req = imem_req;  s_addr = imem_addr;
    s_valid = if_valid; s_instr = if_instr; s_pc = if_pc;
    if (RST) begin
      check_eq("req_in_reset", 32'(s_req), 32'd0);
      mq_addr.delete(); mq_epoch.delete(); mq_due.delete();
      buffered = 0;
      epoch++;
      exp_pc = RESET_PC;
      exp_fetch = RESET_PC;
    end else begin
      if (imem_rvalid) assert (mq_addr.size() > 0) else $error("rvalid with nothing in flight");
      pop_m   = (buffered > 0) && id_ready && !redirect_valid;
      exp_req = !redirect_valid &&
                ((buffered + mq_addr.size() - int'(pop_m)) < int'(DEPTH));
      check_eq("if_valid", 32'(s_valid), 32'(buffered > 0));
      check_eq("imem_req", 32'(s_req), 32'(exp_req));
      if (s_valid && id_ready && !redirect_valid) begin
        dp_cyc.push_back(s_cyc);
        dp_pc.push_back(s_pc);
        dp_instr.push_back(s_instr);
      end
      if (pop_m) begin
        check_eq("if_pc", s_pc, exp_pc);
        check_eq("if_instr", s_instr, mem_word(exp_pc));
        exp_pc += 32'd4;
        buffered--;
      end
      if (s_req) begin
        check_eq("imem_addr", s_addr, exp_fetch);
        if (imem_gnt) begin
          mq_addr.push_back(s_addr);
          mq_epoch.push_back(epoch);
          mq_due.push_back(cyc + lat);
          exp_fetch += 32'd4;
        end
      end
      if (imem_rvalid && mq_addr.size() > 0) begin
        a  = mq_addr.pop_front();
        ep = mq_epoch.pop_front();
        void'(mq_due.pop_front());
        if (ep == epoch && !redirect_valid) buffered++;
        else drops++;
      end
      if (redirect_valid) begin
        epoch++;
        buffered  = 0;
        exp_pc    = redirect_pc & ~32'h3;
        exp_fetch = redirect_pc & ~32'h3;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  initial begin
    int t0, r, drops0, k0;
    logic [31:0] head, held;
    bit found;

    RST = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Reset and first cycle after release
    repeat (3) cycle();
    RST = 1'b0;
    clear_deliveries();
    cycle();
    t0 = s_cyc;
    check_eq("rst_req", 32'(s_req), 32'd1);
    check_eq("rst_addr", s_addr, RESET_PC);
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_instr", s_instr, NOP);
    check_eq("rst_if_pc", s_pc, RESET_PC);

    // Straight line, zero-wait memory
    repeat (6) cycle();
    check_eq("straight_pops", 32'(dp_pc.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < dp_pc.size(); k++) begin
      check_eq("straight_pc", dp_pc[k], 32'(4 * k));
      check_eq("straight_cyc", 32'(dp_cyc[k]), 32'(t0 + 2 + k));
      check_eq("straight_instr", dp_instr[k], mem_word(32'(4 * k)));
    end

    // Backpressure: head holds and requests stop
    id_ready = 1'b0;
    head = '0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 0) head = s_pc;
      else begin
        check_eq("bp_head", s_pc, head);
        check_eq("bp_req", 32'(s_req), 32'd0);
      end
      check_eq("bp_valid", 32'(s_valid), 32'd1);
    end
    id_ready = 1'b1;
    clear_deliveries();
    repeat (6) cycle();
    check_eq("bp_resume_pops", 32'(dp_pc.size() >= 2), 32'd1);
    if (dp_pc.size() >= 2) begin
      check_eq("bp_resume_pc0", dp_pc[0], head);
      check_eq("bp_resume_pc1", dp_pc[1], head + 32'd4);
    end

    // Grant stall: address held, nothing lost
    clear_deliveries();
    imem_gnt = 1'b0;
    held = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 0) held = s_addr;
      else check_eq("stall_addr", s_addr, held);
      check_eq("stall_req", 32'(s_req), 32'd1);
    end
    imem_gnt = 1'b1;
    repeat (8) cycle();
    check_eq("stall_pops", 32'(dp_pc.size() >= 4), 32'd1);
    for (int k = 1; k < dp_pc.size(); k++)
      check_eq("stall_contig", dp_pc[k], dp_pc[k-1] + 32'd4);

    // Redirect with two responses in flight, 3-cycle memory
    lat = 3;
    k0 = 0;
    while (mq_addr.size() != 2 && k0 < 20) begin
      cycle();
      k0++;
    end
    check_eq("wait_two_outstanding", 32'(mq_addr.size()), 32'd2);
    drops0 = drops;
    clear_deliveries();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    r = s_cyc;
    repeat (12) cycle();
    check_eq("redir_drops", 32'(drops - drops0), 32'd2);
    found = 1'b0;
    foreach (dp_cyc[k]) begin
      if (!found && dp_cyc[k] > r) begin
        found = 1'b1;
        check_eq("redir_first_pc", dp_pc[k], 32'h0000_0100);
        check_eq("redir_first_instr", dp_instr[k], mem_word(32'h0000_0100));
      end
    end
    check_eq("redir_delivered", 32'(found), 32'd1);

    // Redirect latency with zero-wait memory
    lat = 1;
    repeat (6) cycle();
    clear_deliveries();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    r = s_cyc;
    check_eq("redir_cycle_req", 32'(s_req), 32'd0);
    cycle();
    check_eq("redir_next_req", 32'(s_req), 32'd1);
    check_eq("redir_next_addr", s_addr, 32'h0000_0200);
    repeat (4) cycle();
    check_eq("redir_lat_pops", 32'(dp_cyc.size() >= 1), 32'd1);
    if (dp_cyc.size() >= 1) check_eq("redir_lat_cyc", 32'(dp_cyc[0]), 32'(r + 3));

    // Reset with the FIFO full and pc at 0x40
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0038;
    id_ready = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    check_eq("full_head_pc", s_pc, 32'h0000_0038);
    check_eq("full_addr", s_addr, 32'h0000_0040);
    check_eq("full_req", 32'(s_req), 32'd0);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    id_ready = 1'b1;
    clear_deliveries();
    cycle();
    check_eq("mid_rst_valid", 32'(s_valid), 32'd0);
    check_eq("mid_rst_addr", s_addr, RESET_PC);
    repeat (5) cycle();
    check_eq("mid_rst_pops", 32'(dp_pc.size() >= 1), 32'd1);
    if (dp_pc.size() >= 1) check_eq("mid_rst_first_pc", dp_pc[0], RESET_PC);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_gnt       = ($urandom_range(0, 4) != 0);
      lat            = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | ($urandom & 32'h3))
                                                   : $urandom;
      RST            = ($urandom_range(0, 299) == 0);
      cycle();
    end
    RST = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    imem_gnt = 1'b1;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
